// File: rtl/cache_invalidate_sequencer.sv
// Invalidate sequencer for the L0 cache: walks every line (or clears one line)
// through the shared cache write port, yielding to pipeline writes and asking for a stall when starved.
module cache_invalidate_sequencer #(
   parameter int CacheIndexWidth = 7,
   parameter int CacheTagWidth   = 7,
   parameter int XLEN            = 32,
   parameter int MaxYield        = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_inval_req,
   input  logic                       i_inval_single,
   input  logic [XLEN-1:0]            i_inval_addr,
   input  logic                       i_pipe_write_enable,
   output logic                       o_req_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_stall_request,
   output logic                       o_cache_write_enable,
   output logic [CacheIndexWidth-1:0] o_cache_write_index,
   output logic [CacheTagWidth-1:0]   o_cache_write_tag,
   output logic [XLEN/8-1:0]          o_cache_write_valid,
   output logic [XLEN-1:0]            o_cache_write_data,
   output logic [XLEN/8-1:0]          o_cache_byte_write_enable
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WALK,
      S_SINGLE,
      S_DONE
   } state_t;

   localparam logic [CacheIndexWidth-1:0] LastIdx   = '1;
   localparam logic [3:0]                 MaxYieldL = 4'(MaxYield);

   state_t                     state;
   logic [CacheIndexWidth-1:0] idx_cnt;
   logic [CacheIndexWidth-1:0] single_idx;
   logic [3:0]                 yield_cnt;
   logic                       wr_state;
   logic                       unused_addr_bits;

   // Only the index field of the address matters; the rest is intentionally ignored.
   assign unused_addr_bits = ^i_inval_addr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= S_IDLE;
         idx_cnt    <= '0;
         single_idx <= '0;
         yield_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_inval_req) begin
                  yield_cnt <= '0;
                  if (i_inval_single) begin
                     single_idx <= i_inval_addr[2 +: CacheIndexWidth];
                     state      <= S_SINGLE;
                  end else begin
                     idx_cnt <= '0;
                     state   <= S_WALK;
                  end
               end
            end
            S_WALK: begin
               if (!i_pipe_write_enable) begin
                  yield_cnt <= '0;
                  // Final line written: stop without wrapping the counter.
                  if (idx_cnt == LastIdx) begin
                     state <= S_DONE;
                  end else begin
                     idx_cnt <= idx_cnt + 1'b1;
                  end
               end else if (yield_cnt != MaxYieldL) begin
                  yield_cnt <= yield_cnt + 4'd1;
               end
            end
            S_SINGLE: begin
               if (!i_pipe_write_enable) begin
                  yield_cnt <= '0;
                  state     <= S_DONE;
               end else if (yield_cnt != MaxYieldL) begin
                  yield_cnt <= yield_cnt + 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      wr_state             = (state == S_WALK) || (state == S_SINGLE);
      o_req_ready          = (state == S_IDLE);
      o_busy               = (state != S_IDLE);
      o_done               = (state == S_DONE);
      o_stall_request      = wr_state && (yield_cnt == MaxYieldL);
      o_cache_write_enable = wr_state && !i_pipe_write_enable;
      case (state)
         S_WALK:   o_cache_write_index = idx_cnt;
         S_SINGLE: o_cache_write_index = single_idx;
         default:  o_cache_write_index = '0;
      endcase
   end

   assign o_cache_write_tag         = '0;
   assign o_cache_write_valid       = '0;
   assign o_cache_write_data        = '0;
   assign o_cache_byte_write_enable = '1;

endmodule

// File: tb/tb_cache_invalidate_sequencer.sv
// Bench for cache_invalidate_sequencer (CacheIndexWidth=3, MaxYield=2): vector table,
// directed multi-cycle sequences and random traffic against a queue-based reference model.
module tb_cache_invalidate_sequencer;

   localparam int IW    = 3;
   localparam int TW    = 7;
   localparam int XL    = 32;
   localparam int MY    = 2;
   localparam int DEPTH = 1 << IW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          single;
   logic [XL-1:0] addr;
   logic          pwe;
   logic          ready, busy, done, stall, we;
   logic [IW-1:0] widx;
   logic [TW-1:0] wtag;
   logic [XL/8-1:0] wvalid;
   logic [XL-1:0] wdata;
   logic [XL/8-1:0] wbe;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: lines still to be written, pending done pulse, yield count
   int unsigned mq[$];
   bit          m_done;
   int          m_yield;

   always #5 clk = ~clk;

   cache_invalidate_sequencer #(
      .CacheIndexWidth(IW),
      .CacheTagWidth(TW),
      .XLEN(XL),
      .MaxYield(MY)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_inval_req(req),
      .i_inval_single(single),
      .i_inval_addr(addr),
      .i_pipe_write_enable(pwe),
      .o_req_ready(ready),
      .o_busy(busy),
      .o_done(done),
      .o_stall_request(stall),
      .o_cache_write_enable(we),
      .o_cache_write_index(widx),
      .o_cache_write_tag(wtag),
      .o_cache_write_valid(wvalid),
      .o_cache_write_data(wdata),
      .o_cache_byte_write_enable(wbe)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_done  = 1'b0;
      m_yield = 0;
   endtask

   task automatic model_step();
      bit nd = 1'b0;
      if (mq.size() > 0) begin
         if (!pwe) begin
            void'(mq.pop_front());
            m_yield = 0;
            if (mq.size() == 0) nd = 1'b1;
         end else if (m_yield < MY) begin
            m_yield++;
         end
      end else if (!m_done && req) begin
         m_yield = 0;
         if (single) mq.push_back(int'((addr >> 2) % DEPTH));
         else for (int i = 0; i < DEPTH; i++) mq.push_back(i);
      end
      m_done = nd;
   endtask

   task automatic model_check(input string tag);
      bit act;
      act = (mq.size() > 0);
      chk({tag, ".ready"}, 32'(ready), 32'(!(act || m_done)));
      chk({tag, ".busy"},  32'(busy),  32'(act || m_done));
      chk({tag, ".done"},  32'(done),  32'(m_done));
      chk({tag, ".we"},    32'(we),    32'(act && !pwe));
      chk({tag, ".idx"},   32'(widx),  act ? mq[0] : 32'd0);
      chk({tag, ".stall"}, 32'(stall), 32'(act && (m_yield == MY)));
      chk({tag, ".const"}, {wtag, wvalid, wdata[0], wbe}, {7'd0, 4'd0, 1'b0, 4'hF});
   endtask

   task automatic drive(input bit r, input bit q, input bit s, input logic [31:0] a, input bit p);
      @(negedge clk);
      rst = r; req = q; single = s; addr = a; pwe = p;
      if (r) model_reset();
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
   endtask

   typedef struct {
      bit          rst, req, single, pwe;
      logic [31:0] addr;
      bit          e_ready, e_busy, e_done, e_we, e_stall;
      int unsigned e_idx;
   } vec_t;

   vec_t vt[12];

   initial begin
      int writes;
      int c;
      rst = 1'b1; req = 1'b0; single = 1'b0; addr = '0; pwe = 1'b0;
      model_reset();

      // rst req sgl pwe addr      rdy bsy dn we stl idx
      vt[0]  = '{1, 0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 1, 0, 32'h1C, 1, 0, 0, 0, 0, 0};
      vt[2]  = '{0, 0, 0, 0, 32'h0,  0, 1, 0, 1, 0, 7};
      vt[3]  = '{0, 0, 0, 0, 32'h0,  0, 1, 1, 0, 0, 0};
      vt[4]  = '{0, 0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0};
      vt[5]  = '{0, 1, 1, 1, 32'h14, 1, 0, 0, 0, 0, 0};
      vt[6]  = '{0, 0, 0, 1, 32'h0,  0, 1, 0, 0, 0, 5};
      vt[7]  = '{0, 0, 0, 1, 32'h0,  0, 1, 0, 0, 0, 5};
      vt[8]  = '{0, 0, 0, 1, 32'h0,  0, 1, 0, 0, 1, 5};
      vt[9]  = '{0, 0, 0, 0, 32'h0,  0, 1, 0, 1, 1, 5};
      vt[10] = '{0, 0, 0, 0, 32'h0,  0, 1, 1, 0, 0, 0};
      vt[11] = '{0, 0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0};

      for (int i = 0; i < 12; i++) begin
         drive(vt[i].rst, vt[i].req, vt[i].single, vt[i].addr, vt[i].pwe);
         chk($sformatf("vec%0d.ready", i), 32'(ready), 32'(vt[i].e_ready));
         chk($sformatf("vec%0d.busy", i),  32'(busy),  32'(vt[i].e_busy));
         chk($sformatf("vec%0d.done", i),  32'(done),  32'(vt[i].e_done));
         chk($sformatf("vec%0d.we", i),    32'(we),    32'(vt[i].e_we));
         chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vt[i].e_stall));
         chk($sformatf("vec%0d.idx", i),   32'(widx),  vt[i].e_idx);
         model_check($sformatf("vec%0d", i));
         advance();
      end

      // Uncontended full walk
      drive(0, 1, 0, 0, 0);
      advance();
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 0);
         chk("walk.we", 32'(we), 32'd1);
         chk("walk.idx", 32'(widx), 32'(i));
         model_check("walk");
         advance();
      end
      drive(0, 0, 0, 0, 0);
      chk("walk.done", 32'(done), 32'd1);
      advance();
      drive(0, 0, 0, 0, 0);
      chk("walk.ready_after", 32'(ready), 32'd1);
      advance();

      // Contended walk with a request pulse while busy
      drive(0, 1, 0, 0, 0);
      advance();
      writes = 0;
      c = 1;
      while (writes < DEPTH && c <= 20) begin
         drive(0, (c == 6), 0, 0, (c == 3 || c == 4));
         model_check("cont");
         if (c == 3 || c == 4) chk("cont.yield_we", 32'(we), 32'd0);
         if (c == 5) chk("cont.stall_set", 32'(stall), 32'd1);
         if (c == 6) begin
            chk("cont.stall_clr", 32'(stall), 32'd0);
            chk("cont.busy_ready", 32'(ready), 32'd0);
         end
         if (we) begin
            chk("cont.order", 32'(widx), 32'(writes));
            writes++;
         end
         advance();
         c++;
      end
      chk("cont.writes", 32'(writes), 32'(DEPTH));
      drive(0, 0, 0, 0, 0);
      chk("cont.done", 32'(done), 32'd1);
      model_check("cont_done");
      advance();

      // Reset while the walk sits at index 4
      drive(0, 1, 0, 0, 0);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0);
         advance();
      end
      drive(0, 0, 0, 0, 0);
      chk("rstmid.pre_idx", 32'(widx), 32'd4);
      drive(1, 0, 0, 0, 0);
      chk("rstmid.we", 32'(we), 32'd0);
      chk("rstmid.ready", 32'(ready), 32'd1);
      model_check("rstmid");
      advance();
      drive(0, 0, 0, 0, 0);
      chk("rstmid.no_resume", 32'(busy), 32'd0);
      advance();
      drive(0, 1, 0, 0, 0);
      advance();
      drive(0, 0, 0, 0, 0);
      chk("rstmid.restart_idx", 32'(widx), 32'd0);
      chk("rstmid.restart_we", 32'(we), 32'd1);
      advance();

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
               $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 9) < 3));
         model_check("rand");
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
